disp_frame_reader: RTL and testbench

DISP_FRAME_READER -- requirements
Module: disp_frame_reader

---
 rtl/disp_frame_reader_pkg.sv | 17 +
 rtl/sync_edge.sv | 21 ++
 rtl/disp_frame_reader.sv | 133 +++++++++++++
 tb/tb_disp_frame_reader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_frame_reader_pkg.sv
// Shared constants and state encoding for the display frame reader and the memory read arbiter.
package disp_frame_reader_pkg;

    localparam int RD_LEN_W    = 9;
    localparam int FIFO_USED_W = 11;
    localparam int FILL_CMP_W  = 12;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WAIT_SPACE,
        REQ,
        DATA,
        DONE
    } rd_state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, plus a third flop for rising-edge detection.
module sync_edge (
    input  logic mem_clock,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic [2:0] sync_q;

    always_ff @(posedge mem_clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], async_in};
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/disp_frame_reader.sv
// Streams one frame from the frame buffer into the display read FIFO as length-limited bursts,
// restarting cleanly whenever the display stage signals a new frame.
module disp_frame_reader
    import disp_frame_reader_pkg::*;
#(
    parameter int FRAME_WORDS = 384000,
    parameter int BASE_ADDR   = 0,
    parameter int BURST_LEN   = 128,
    parameter int FIFO_DEPTH  = 1024,
    parameter int ADDR_W      = 24
) (
    input  logic                   mem_clock,
    input  logic                   reset,
    input  logic                   rd_load,
    output logic                   rd_req,
    output logic [ADDR_W-1:0]      rd_addr,
    output logic [RD_LEN_W-1:0]    rd_len,
    input  logic                   rd_ack,
    input  logic                   rd_valid,
    input  logic [31:0]            rd_data,
    output logic                   fifo_clr,
    output logic                   fifo_wren,
    output logic [31:0]            fifo_din,
    input  logic [FIFO_USED_W-1:0] fifo_used
);

    rd_state_t             state, state_nx;
    logic                  frame_start;
    logic                  restart_pend;
    logic [ADDR_W-1:0]     addr;
    logic [31:0]           remaining;
    logic [RD_LEN_W-1:0]   beat_cnt;
    logic [RD_LEN_W-1:0]   len;
    logic [FILL_CMP_W-1:0] fill_sum;
    logic                  space_ok;
    logic                  last_beat;

    sync_edge u_sync_edge (
        .mem_clock (mem_clock),
        .reset     (reset),
        .async_in  (rd_load),
        .rise      (frame_start)
    );

    // remaining only changes at the end of a burst, so len stays stable through REQ and DATA
    always_comb begin
        len = RD_LEN_W'(BURST_LEN);
        if (remaining < 32'(BURST_LEN)) begin
            len = RD_LEN_W'(remaining);
        end
    end

    assign fill_sum  = FILL_CMP_W'(fifo_used) + FILL_CMP_W'(len);
    assign space_ok  = (fill_sum <= FILL_CMP_W'(FIFO_DEPTH));
    assign last_beat = (state == DATA) && rd_valid && (beat_cnt == len - 1'b1);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       if (frame_start) state_nx = CLEAR;
            CLEAR:      state_nx = WAIT_SPACE;
            WAIT_SPACE: begin
                if (frame_start) begin
                    state_nx = CLEAR;
                end else if (space_ok) begin
                    state_nx = REQ;
                end
            end
            REQ:        if (rd_ack) state_nx = DATA;
            DATA: begin
                if (last_beat) begin
                    if (restart_pend || frame_start) begin
                        state_nx = CLEAR;
                    end else if (remaining == 32'(len)) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = WAIT_SPACE;
                    end
                end
            end
            DONE:       if (frame_start) state_nx = CLEAR;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge mem_clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            beat_cnt  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                CLEAR: begin
                    addr      <= ADDR_W'(BASE_ADDR);
                    remaining <= 32'(FRAME_WORDS);
                    beat_cnt  <= '0;
                end
                REQ: beat_cnt <= '0;
                DATA: begin
                    if (last_beat) begin
                        beat_cnt  <= '0;
                        addr      <= addr + ADDR_W'(len);
                        remaining <= remaining - 32'(len);
                    end else if (rd_valid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // An issued request cannot be withdrawn, so a restart during REQ/DATA waits for the burst to drain
    always_ff @(posedge mem_clock or posedge reset) begin
        if (reset) begin
            restart_pend <= 1'b0;
        end else if (state_nx == CLEAR) begin
            restart_pend <= 1'b0;
        end else if (frame_start && (state == REQ || state == DATA)) begin
            restart_pend <= 1'b1;
        end
    end

    assign rd_req    = (state == REQ);
    assign rd_addr   = rd_req ? addr : '0;
    assign rd_len    = rd_req ? len : '0;
    assign fifo_clr  = (state == CLEAR);
    assign fifo_wren = (state == DATA) && rd_valid && !restart_pend;
    assign fifo_din  = fifo_wren ? rd_data : '0;

endmodule

// File: tb/tb_disp_frame_reader.sv
// Directed bench for disp_frame_reader: a 300-word frame in 128-word bursts, FIFO back-pressure,
// slow acknowledge, restarts during REQ and DATA, and reset during a burst.
module tb_disp_frame_reader;
    import disp_frame_reader_pkg::*;

    localparam int FW = 300;
    localparam int BL = 128;
    localparam int FD = 1024;
    localparam int AW = 24;

    logic                   mem_clock = 1'b0;
    logic                   reset;
    logic                   rd_load;
    logic                   rd_req;
    logic [AW-1:0]          rd_addr;
    logic [RD_LEN_W-1:0]    rd_len;
    logic                   rd_ack;
    logic                   rd_valid;
    logic [31:0]            rd_data;
    logic                   fifo_clr;
    logic                   fifo_wren;
    logic [31:0]            fifo_din;
    logic [FIFO_USED_W-1:0] fifo_used;

    int          checks = 0;
    int          passes = 0;
    int          wr_cnt = 0;
    int          clr_cnt = 0;
    int          req_cnt = 0;
    logic [31:0] wr_sum = '0;

    disp_frame_reader #(
        .FRAME_WORDS (FW),
        .BASE_ADDR   (0),
        .BURST_LEN   (BL),
        .FIFO_DEPTH  (FD),
        .ADDR_W      (AW)
    ) dut (
        .mem_clock (mem_clock),
        .reset     (reset),
        .rd_load   (rd_load),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_len    (rd_len),
        .rd_ack    (rd_ack),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .fifo_clr  (fifo_clr),
        .fifo_wren (fifo_wren),
        .fifo_din  (fifo_din),
        .fifo_used (fifo_used)
    );

    always #5 mem_clock = ~mem_clock;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later
    task automatic applyStimulus(input logic ack, input logic valid, input logic [31:0] data);
        @(negedge mem_clock);
        rd_ack   = ack;
        rd_valid = valid;
        rd_data  = data;
        #1;
        if (fifo_wren === 1'b1) begin
            wr_cnt++;
            wr_sum += fifo_din;
        end
        if (fifo_clr === 1'b1) clr_cnt++;
        if (rd_req === 1'b1) req_cnt++;
    endtask

    task automatic waitReq(input string tag, output bit found);
        found = (rd_req === 1'b1);
        for (int i = 0; i < 200 && !found; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            found = (rd_req === 1'b1);
        end
        checkOutput({tag, "_req_seen"}, 32'(found), 32'd1);
    endtask

    task automatic serveBurst(input string tag, input int exp_addr, input int exp_len,
                              input int ack_delay, input int load_beat, input int exp_writes);
        bit          found;
        int          bad;
        int          wr0;
        logic [31:0] sum0;
        logic [31:0] exp_sum;
        logic [31:0] d;
        waitReq(tag, found);
        if (found) begin
            checkOutput({tag, "_addr"}, 32'(rd_addr), 32'(exp_addr));
            checkOutput({tag, "_len"}, 32'(rd_len), 32'(exp_len));
            bad = 0;
            for (int i = 0; i < ack_delay; i++) begin
                applyStimulus(1'b0, 1'b0, 32'h0);
                if (rd_req !== 1'b1 || rd_addr !== AW'(exp_addr) || rd_len !== RD_LEN_W'(exp_len)) bad++;
            end
            if (ack_delay > 0) checkOutput({tag, "_stable"}, 32'(bad), 32'd0);
            applyStimulus(1'b1, 1'b0, 32'h0);
            wr0     = wr_cnt;
            sum0    = wr_sum;
            exp_sum = '0;
            for (int i = 1; i <= exp_len; i++) begin
                d = {8'hA5, 24'(exp_addr + i - 1)};
                applyStimulus(1'b0, 1'b1, d);
                if (i <= exp_writes) exp_sum += d;
                if (i == load_beat) rd_load = 1'b1;
            end
            applyStimulus(1'b0, 1'b0, 32'h0);
            checkOutput({tag, "_writes"}, 32'(wr_cnt - wr0), 32'(exp_writes));
            checkOutput({tag, "_sum"}, wr_sum - sum0, exp_sum);
        end
    endtask

    initial begin
        bit found;
        int first_clr;
        int clr0;
        int req0;
        int wr0;
        int low_req;

        reset     = 1'b1;
        rd_load   = 1'b0;
        rd_ack    = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = '0;
        fifo_used = '0;

        // Reset: outputs idle even with a data beat presented
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 32'hDEADBEEF);
        checkOutput("rst_req", 32'(rd_req), 32'd0);
        checkOutput("rst_wren", 32'(fifo_wren), 32'd0);
        checkOutput("rst_clr", 32'(fifo_clr), 32'd0);
        checkOutput("rst_addr", 32'(rd_addr), 32'd0);
        checkOutput("rst_len", 32'(rd_len), 32'd0);
        checkOutput("rst_din", fifo_din, 32'd0);
        checkOutput("rst_state", 32'(dut.state), 32'(IDLE));

        reset = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h12345678);
        checkOutput("idle_stray_wren", 32'(fifo_wren), 32'd0);
        checkOutput("idle_req_cnt", 32'(req_cnt), 32'd0);
        checkOutput("idle_clr_cnt", 32'(clr_cnt), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0);

        // Scenario A: one full frame, fifo_clr three cycles after rd_load rises
        $display("[TB] scenario A: full frame");
        rd_load   = 1'b1;
        first_clr = 0;
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            if (fifo_clr === 1'b1 && first_clr == 0) first_clr = k;
        end
        rd_load = 1'b0;
        checkOutput("A_clr_latency", 32'(first_clr), 32'd3);
        serveBurst("A0", 0, 128, 0, 0, 128);
        serveBurst("A1", 128, 128, 0, 0, 128);
        serveBurst("A2", 256, 44, 0, 0, 44);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("A_total_writes", 32'(wr_cnt), 32'd300);
        checkOutput("A_clr_count", 32'(clr_cnt), 32'd1);
        checkOutput("A_state_done", 32'(dut.state), 32'(DONE));
        checkOutput("A_no_req", 32'(rd_req), 32'd0);
        applyStimulus(1'b0, 1'b1, 32'hCAFEF00D);
        checkOutput("A_done_stray_wren", 32'(fifo_wren), 32'd0);

        // Scenario B: FIFO back-pressure; 896 + 128 = 1024 is the first level that fits
        $display("[TB] scenario B: back-pressure");
        fifo_used = 11'd950;
        clr0      = clr_cnt;
        rd_load   = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'h0);
        rd_load = 1'b0;
        checkOutput("B_clr", 32'(clr_cnt - clr0), 32'd1);
        req0 = req_cnt;
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("B_hold_950", 32'(req_cnt - req0), 32'd0);
        fifo_used = 11'd897;
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("B_hold_897", 32'(req_cnt - req0), 32'd0);
        checkOutput("B_state_wait", 32'(dut.state), 32'(WAIT_SPACE));
        fifo_used = 11'd896;
        serveBurst("B", 0, 128, 0, 0, 128);
        fifo_used = 11'd0;

        // Scenario C: acknowledge withheld for 20 cycles
        $display("[TB] scenario C: slow ack");
        serveBurst("C", 128, 128, 20, 0, 128);

        // Scenario F: two restarts while the final request is outstanding
        $display("[TB] scenario F: double restart in REQ");
        waitReq("F", found);
        checkOutput("F_len", 32'(rd_len), 32'd44);
        clr0    = clr_cnt;
        wr0     = wr_cnt;
        low_req = 0;
        rd_load = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            if (rd_req !== 1'b1) low_req++;
            if (c == 2) rd_load = 1'b0;
            if (c == 4) rd_load = 1'b1;
            if (c == 6) rd_load = 1'b0;
        end
        checkOutput("F_req_held", 32'(low_req), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 44; i++) applyStimulus(1'b0, 1'b1, 32'h5A5A0000 + 32'(i));
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("F_drain_writes", 32'(wr_cnt - wr0), 32'd0);
        checkOutput("F_one_clr", 32'(clr_cnt - clr0), 32'd1);

        // Scenario D: restart seen during beat 40 leaves only 40 writes, then a fresh frame
        $display("[TB] scenario D: restart in DATA");
        clr0 = clr_cnt;
        serveBurst("D", 0, 128, 0, 38, 40);
        rd_load = 1'b0;
        checkOutput("D_clr", 32'(clr_cnt - clr0), 32'd1);

        // Scenario E: reset during a burst
        $display("[TB] scenario E: reset in DATA");
        waitReq("E", found);
        checkOutput("E_addr", 32'(rd_addr), 32'd0);
        checkOutput("E_len", 32'(rd_len), 32'd128);
        applyStimulus(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 32'h77000000 + 32'(i));
        @(negedge mem_clock);
        reset    = 1'b1;
        rd_valid = 1'b1;
        rd_data  = 32'h0BADBEEF;
        #1;
        checkOutput("E_rst_req", 32'(rd_req), 32'd0);
        checkOutput("E_rst_wren", 32'(fifo_wren), 32'd0);
        checkOutput("E_rst_din", fifo_din, 32'd0);
        checkOutput("E_rst_addr", 32'(rd_addr), 32'd0);
        checkOutput("E_rst_state", 32'(dut.state), 32'(IDLE));
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 32'h0BADBEEF);
        reset = 1'b0;
        wr0   = wr_cnt;
        req0  = req_cnt;
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 32'h66000000 + 32'(i));
        checkOutput("E_stray_writes", 32'(wr_cnt - wr0), 32'd0);
        checkOutput("E_stray_req", 32'(req_cnt - req0), 32'd0);
        checkOutput("E_state_idle", 32'(dut.state), 32'(IDLE));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
